// File: rtl/ascii_pkg.sv
// ---------------------------------------------------------------------------
// ascii_pkg
// Character constants and the transmitter state encoding shared by
// word_to_ascii_tx and nibble_to_ascii (and later the debug dump block).
// ---------------------------------------------------------------------------
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO    = 8'd48;
    localparam logic [7:0] ASCII_ONE     = 8'd49;
    localparam logic [7:0] ASCII_A       = 8'd65;
    localparam logic [7:0] ASCII_SPACE   = 8'd32;
    localparam logic [7:0] ASCII_CAR_RET = 8'd13;
    localparam logic [7:0] ASCII_NEWLINE = 8'd10;

    typedef enum logic [2:0] {
        IDLE,
        DIGIT,
        SEP,
        CR,
        LF
    } tx_state_t;

endpackage

// File: rtl/word_to_ascii_tx_if.sv
// ---------------------------------------------------------------------------
// word_to_ascii_tx_if
// Control/data bundle between the result-register side (master) and the
// word_to_ascii_tx serialiser (slave), including the uart_tx write path.
//   en_16_x_baud  pacing enable          (master -> slave)
//   send          start request          (master -> slave)
//   hex_mode      0 = binary, 1 = hex    (master -> slave)
//   data_in[N]    word to transmit       (master -> slave)
//   buffer_full   UART FIFO full         (master -> slave)
//   ascii_out[8]  current character      (slave -> master)
//   write_buffer  UART write strobe      (slave -> master)
//   busy          message in progress    (slave -> master)
//   done          end-of-message pulse   (slave -> master)
// ---------------------------------------------------------------------------
interface word_to_ascii_tx_if #(
    parameter int N = 48
) ();

    logic         en_16_x_baud;
    logic         send;
    logic         hex_mode;
    logic [N-1:0] data_in;
    logic         buffer_full;
    logic [7:0]   ascii_out;
    logic         write_buffer;
    logic         busy;
    logic         done;

    modport master (
        output en_16_x_baud, send, hex_mode, data_in, buffer_full,
        input  ascii_out, write_buffer, busy, done
    );

    modport slave (
        input  en_16_x_baud, send, hex_mode, data_in, buffer_full,
        output ascii_out, write_buffer, busy, done
    );

endinterface

// File: rtl/nibble_to_ascii.sv
// ---------------------------------------------------------------------------
// nibble_to_ascii
// Combinational hex digit mapper: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
//   nibble[4]  input value
//   ascii[8]   character code
// ---------------------------------------------------------------------------
module nibble_to_ascii
    import ascii_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'd0, nibble};
        end else begin
            ascii = ASCII_A + {4'd0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/word_to_ascii_tx.sv
// ---------------------------------------------------------------------------
// word_to_ascii_tx
// Serialises an N-bit word into ASCII binary or hex digits (MSB first) for
// uart_tx, with optional space-separated digit groups and a CR LF trailer.
// Output is paced by en_16_x_baud and held off while buffer_full is high.
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    word_to_ascii_tx_if slave (send/data in, character/strobe out)
// ---------------------------------------------------------------------------
module word_to_ascii_tx
    import ascii_pkg::*;
#(
    parameter int N     = 48,
    parameter int GROUP = 0,
    parameter int CRLF  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    word_to_ascii_tx_if.slave     bus
);

    localparam int HEX_DIGITS = (N + 3) / 4;
    // The shift register is wide enough to hold the zero-padded hex view.
    localparam int SW = 4 * HEX_DIGITS;
    localparam int DW = $clog2(N + 1);
    localparam int GW = (GROUP > 0) ? $clog2(GROUP + 1) : 1;

    localparam logic [DW-1:0] BIN_CNT    = DW'(N);
    localparam logic [DW-1:0] HEX_CNT    = DW'(HEX_DIGITS);
    localparam logic [GW-1:0] GROUP_LAST = GW'((GROUP == 0) ? 0 : GROUP - 1);

    tx_state_t       state;
    logic [SW-1:0]   shreg;
    logic            hex_q;
    logic [DW-1:0]   digit_cnt;
    logic [GW-1:0]   group_cnt;
    logic            busy_q;
    logic            done_q;

    logic            emit;
    logic            digit_last;
    logic            group_last;
    logic [7:0]      hex_char;
    logic [7:0]      digit_char;
    logic [7:0]      ascii_q;

    nibble_to_ascii u_nibble (
        .nibble (shreg[SW-1 -: 4]),
        .ascii  (hex_char)
    );

    assign emit       = (state != IDLE) && bus.en_16_x_baud && !bus.buffer_full;
    assign digit_last = (digit_cnt == DW'(1));
    assign group_last = (GROUP != 0) && (group_cnt == GROUP_LAST);
    assign digit_char = hex_q ? hex_char : (shreg[SW-1] ? ASCII_ONE : ASCII_ZERO);

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        ascii_q = 8'h00;
        case (state)
            DIGIT:   ascii_q = digit_char;
            SEP:     ascii_q = ASCII_SPACE;
            CR:      ascii_q = ASCII_CAR_RET;
            LF:      ascii_q = ASCII_NEWLINE;
            default: ascii_q = 8'h00;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            hex_q     <= 1'b0;
            digit_cnt <= '0;
            group_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.send) begin
                        // Binary is left-aligned so its MSB sits at the top;
                        // hex keeps the word right-aligned with zero pad above.
                        shreg     <= bus.hex_mode ? SW'(bus.data_in)
                                                  : SW'(bus.data_in) << (SW - N);
                        hex_q     <= bus.hex_mode;
                        digit_cnt <= bus.hex_mode ? HEX_CNT : BIN_CNT;
                        group_cnt <= '0;
                        busy_q    <= 1'b1;
                        state     <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (emit) begin
                        shreg     <= hex_q ? (shreg << 4) : (shreg << 1);
                        digit_cnt <= digit_cnt - 1'b1;
                        // Last-digit test comes first so no trailing separator.
                        if (digit_last) begin
                            group_cnt <= '0;
                            if (CRLF != 0) begin
                                state <= CR;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end else if (group_last) begin
                            group_cnt <= '0;
                            state     <= SEP;
                        end else begin
                            group_cnt <= group_cnt + 1'b1;
                        end
                    end
                end
                SEP: begin
                    if (emit) state <= DIGIT;
                end
                CR: begin
                    if (emit) state <= LF;
                end
                LF: begin
                    if (emit) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ascii_out    = ascii_q;
    assign bus.write_buffer = emit;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_word_to_ascii_tx.sv
// ---------------------------------------------------------------------------
// tb_word_to_ascii_tx
// Three instances cover the parameter corners:
//   u0: N=8,  GROUP=0, CRLF=1
//   u1: N=8,  GROUP=4, CRLF=1
//   u2: N=10, GROUP=0, CRLF=0
// Expected characters are generated from the word when send is driven and
// compared as each write_buffer strobe is observed.
// ---------------------------------------------------------------------------
module tb_word_to_ascii_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    word_to_ascii_tx_if #(.N(8))  if0 ();
    word_to_ascii_tx_if #(.N(8))  if1 ();
    word_to_ascii_tx_if #(.N(10)) if2 ();

    word_to_ascii_tx #(.N(8),  .GROUP(0), .CRLF(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
    word_to_ascii_tx #(.N(8),  .GROUP(4), .CRLF(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    word_to_ascii_tx #(.N(10), .GROUP(0), .CRLF(0)) u2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct {
        logic [7:0] ch;
        bit         last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit pend[3];
    int done_cyc[3];
    int wr_cnt[3];
    int start_cyc[3];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int q_size(int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_pop(int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void q_push(int id, exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic logic busy_of(int id);
        case (id)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    // Reference model: the character stream one message should produce.
    function automatic void build_msg(int id, logic [15:0] data, bit hex);
        int   n  = (id == 2) ? 10 : 8;
        int   g  = (id == 1) ? 4 : 0;
        bit   c  = (id != 2);
        int   nd = hex ? (n + 3) / 4 : n;
        exp_t e;
        logic [3:0] nib;
        for (int i = 0; i < nd; i++) begin
            if (hex) begin
                nib  = 4'(data >> (4 * (nd - 1 - i)));
                e.ch = (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
            end else begin
                e.ch = data[n - 1 - i] ? 8'd49 : 8'd48;
            end
            e.last = !c && (i == nd - 1);
            q_push(id, e);
            if (g != 0 && i != nd - 1 && (i + 1) % g == 0) begin
                e.ch = 8'd32; e.last = 1'b0; q_push(id, e);
            end
        end
        if (c) begin
            e.ch = 8'd13; e.last = 1'b0; q_push(id, e);
            e.ch = 8'd10; e.last = 1'b1; q_push(id, e);
        end
    endfunction

    task automatic mon(int id, logic wb, logic [7:0] ch, logic dn, logic en, logic full);
        exp_t e;
        if (dn || pend[id]) begin
            check($sformatf("done%0d", id), dn, pend[id]);
            if (dn) done_cyc[id] = cyc;
        end
        pend[id] = 1'b0;
        if (wb) begin
            check($sformatf("wr_gated%0d", id), en & ~full, 1);
            if (q_size(id) == 0) begin
                check($sformatf("wr_extra%0d", id), wb, 0);
            end else begin
                e = q_pop(id);
                check($sformatf("char%0d_%0d", id, wr_cnt[id]), ch, e.ch);
                wr_cnt[id]++;
                if (e.last) pend[id] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, if0.write_buffer, if0.ascii_out, if0.done, if0.en_16_x_baud, if0.buffer_full);
        mon(1, if1.write_buffer, if1.ascii_out, if1.done, if1.en_16_x_baud, if1.buffer_full);
        mon(2, if2.write_buffer, if2.ascii_out, if2.done, if2.en_16_x_baud, if2.buffer_full);
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(int id, logic s, logic [15:0] d, logic h);
        case (id)
            0: begin if0.send = s; if0.data_in = d[7:0]; if0.hex_mode = h; end
            1: begin if1.send = s; if1.data_in = d[7:0]; if1.hex_mode = h; end
            default: begin if2.send = s; if2.data_in = d[9:0]; if2.hex_mode = h; end
        endcase
    endtask

    task automatic start(int id, logic [15:0] d, bit h);
        set_in(id, 1'b1, d, h);
        build_msg(id, d, h);
        start_cyc[id] = cyc;
        tick();
        set_in(id, 1'b0, d, h);
    endtask

    task automatic wait_msg(int id, int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (q_size(id) == 0 && !pend[id] && !busy_of(id)) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("finish%0d", id), ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   base;
        int   fw;
        bit   trig;
        bit   ok;

        if0.en_16_x_baud = 1'b1; if0.buffer_full = 1'b0;
        if1.en_16_x_baud = 1'b1; if1.buffer_full = 1'b0;
        if2.en_16_x_baud = 1'b1; if2.buffer_full = 1'b0;
        set_in(0, 1'b0, 16'h0, 1'b0);
        set_in(1, 1'b0, 16'h0, 1'b0);
        set_in(2, 1'b0, 16'h0, 1'b0);

        // Reset state.
        repeat (3) tick();
        check("rst_wb",    if0.write_buffer, 0);
        check("rst_busy",  if0.busy,         0);
        check("rst_done",  if0.done,         0);
        check("rst_ascii", if0.ascii_out,    0);
        reset = 1'b0;
        tick();

        // Binary A5: 10 back-to-back writes, done on the 11th cycle.
        base = wr_cnt[0];
        start(0, 16'h00A5, 1'b0);
        check("busy_hi", if0.busy, 1);
        wait_msg(0, 100);
        check("len_bin", done_cyc[0] - start_cyc[0], 11);
        check("cnt_bin", wr_cnt[0] - base, 10);
        check("busy_lo", if0.busy, 0);
        check("idle_char", if0.ascii_out, 0);

        // Hex A5: 'A','5',CR,LF.
        base = wr_cnt[0];
        start(0, 16'h00A5, 1'b1);
        wait_msg(0, 100);
        check("len_hex", done_cyc[0] - start_cyc[0], 5);
        check("cnt_hex", wr_cnt[0] - base, 4);

        // Grouped binary: "1010 0101" CR LF, 11 writes.
        base = wr_cnt[1];
        start(1, 16'h00A5, 1'b0);
        wait_msg(1, 100);
        check("len_grp", done_cyc[1] - start_cyc[1], 12);
        check("cnt_grp", wr_cnt[1] - base, 11);
        start(1, 16'h00A5, 1'b1);
        wait_msg(1, 100);
        check("len_grp_hex", done_cyc[1] - start_cyc[1], 5);

        // N=10, no terminator: hex 3FF -> "3FF"; binary 2A5 -> 10 digits.
        base = wr_cnt[2];
        start(2, 16'h03FF, 1'b1);
        wait_msg(2, 100);
        check("len_3ff", done_cyc[2] - start_cyc[2], 4);
        check("cnt_3ff", wr_cnt[2] - base, 3);
        start(2, 16'h02A5, 1'b0);
        wait_msg(2, 100);
        check("len_n10_bin", done_cyc[2] - start_cyc[2], 11);

        // Paced 1-in-16 with a 5-cycle buffer_full window after the 2nd char.
        base = wr_cnt[0];
        trig = 1'b0;
        fw   = 0;
        ok   = 1'b0;
        if0.en_16_x_baud = 1'b0;
        start(0, 16'h003C, 1'b0);
        for (int k = 1; k < 2000; k++) begin
            if (!trig && wr_cnt[0] - base >= 2) begin
                trig = 1'b1;
                fw   = 5;
            end
            if0.buffer_full  = (fw > 0);
            if0.en_16_x_baud = (k % 16 == 0) || (fw > 0);
            if (fw > 0) fw--;
            tick();
            if (q_size(0) == 0 && !pend[0] && !if0.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_finish", ok, 1);
        check("stall_cnt", wr_cnt[0] - base, 10);
        if0.en_16_x_baud = 1'b1;
        if0.buffer_full  = 1'b0;
        tick();

        // Send while busy is ignored; send in the done cycle is accepted.
        start(0, 16'h005A, 1'b0);
        repeat (3) tick();
        set_in(0, 1'b1, 16'h00FF, 1'b1);
        tick();
        set_in(0, 1'b0, 16'h0000, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (if0.done) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b_first_done", ok, 1);
        start(0, 16'h00C3, 1'b1);
        wait_msg(0, 100);
        check("len_b2b", done_cyc[0] - start_cyc[0], 5);

        // Reset after the 3rd character aborts the message.
        base = wr_cnt[0];
        start(0, 16'h0096, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (wr_cnt[0] - base == 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach3", ok, 1);
        reset = 1'b1;
        q0.delete();
        pend[0] = 1'b0;
        tick();
        check("abort_wb",    if0.write_buffer, 0);
        check("abort_busy",  if0.busy,         0);
        check("abort_ascii", if0.ascii_out,    0);
        check("abort_done",  if0.done,         0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        check("abort_cnt", wr_cnt[0] - base, 3);

        // Fresh message after the abort.
        base = wr_cnt[0];
        start(0, 16'h0096, 1'b0);
        wait_msg(0, 100);
        check("len_after_rst", done_cyc[0] - start_cyc[0], 11);
        check("cnt_after_rst", wr_cnt[0] - base, 10);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
